// File: rtl/arb_pkg.sv
// Shared types and defaults for the unified-memory port arbiter.
// State and owner encodings are visible to the top and its bench.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

  localparam int ARB_AW         = 32;
  localparam int ARB_DW         = 32;
  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_TIMEOUT    = 64;

endpackage

// File: rtl/arb_timeout_timer.sv
// Busy-cycle counter; expire flags the last allowed cycle of an access.
// Clears itself on expiry so the next access starts from zero.
module arb_timeout_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [TW-1:0] cnt_q;
  logic [TW-1:0] cnt_d;

  assign expire = en & (cnt_q == TW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr || expire) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between fetch and data requesters.
// Data has priority; a starvation counter forces fetch through.
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int AW         = ARB_AW,
  parameter int DW         = ARB_DW,
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic          dm_rvalid,
  output logic [DW-1:0] dm_rdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic [DW-1:0] mem_rdata,
  output logic          stall,
  output logic          timeout_err
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  arb_state_e    state_q, state_d;
  arb_owner_e    owner_q, owner_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          if_rvalid_q, if_rvalid_d;
  logic          dm_rvalid_q, dm_rvalid_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] dm_rdata_q, dm_rdata_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          terr_q, terr_d;

  logic          busy;
  logic          tmo_expire;
  logic [DW-1:0] rd_data;

  assign busy = (state_q == BUSY_IF) | (state_q == BUSY_DM);

  arb_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_tmr (
    .clk     (clk),
    .rst     (rst),
    .clr     (~busy | mem_ready),
    .en      (busy),
    .expire  (tmo_expire)
  );

  // A timed-out access returns zero data rather than bus garbage.
  assign rd_data = mem_ready ? mem_rdata : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    dm_rvalid_d = 1'b0;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    starve_d    = starve_q;
    terr_d      = terr_q;
    unique case (state_q)
      IDLE: begin
        if (dm_req && (!if_req || starve_q < SW'(STARVE_MAX))) begin
          state_d     = BUSY_DM;
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          if (!if_req) begin
            starve_d = '0;
          end else if (starve_q != SW'(STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
          end
        end else if (if_req) begin
          state_d     = BUSY_IF;
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end else begin
          starve_d = '0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ready || tmo_expire) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          terr_d    = terr_q | ~mem_ready;
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = rd_data;
          end else begin
            dm_rvalid_d = 1'b1;
            dm_rdata_d  = mem_we_q ? '0 : rd_data;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      starve_q    <= '0;
      terr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      dm_rvalid_q <= dm_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      starve_q    <= starve_d;
      terr_q      <= terr_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign if_rvalid   = if_rvalid_q;
  assign dm_rvalid   = dm_rvalid_q;
  assign if_rdata    = if_rdata_q;
  assign dm_rdata    = dm_rdata_q;
  assign timeout_err = terr_q;

  assign stall = (if_req & ~if_rvalid_q) | (dm_req & ~dm_rvalid_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a latency-programmable memory.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0;
  logic        dm_we = 1'b0;
  logic [31:0] dm_addr = '0;
  logic [31:0] dm_wdata = '0;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        stall;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Memory model: ready on the lat-th cycle of mem_req; lat = 0 never.
  int          lat = 1;
  logic [31:0] rdata_val = '0;
  int          busy_cycles = 0;

  mem_port_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rvalid   (if_rvalid),
    .if_rdata    (if_rdata),
    .dm_req      (dm_req),
    .dm_we       (dm_we),
    .dm_addr     (dm_addr),
    .dm_wdata    (dm_wdata),
    .dm_rvalid   (dm_rvalid),
    .dm_rdata    (dm_rdata),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata),
    .stall       (stall),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_req) begin
      busy_cycles = busy_cycles + 1;
      mem_ready   = (lat != 0) && (busy_cycles == lat);
      mem_rdata   = rdata_val;
    end else begin
      busy_cycles = 0;
      mem_ready   = 1'b0;
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({mem_req, mem_we, if_rvalid, dm_rvalid, timeout_err, stall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 000000",
               {mem_req, mem_we, if_rvalid, dm_rvalid, timeout_err, stall});
    end
    checks++;
    if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== 128'h0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0",
               mem_addr, mem_wdata, if_rdata, dm_rdata);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    lat = 1;
    rdata_val = 32'h0050_0093;
    if_addr = 32'h10;
    if_req = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b1) begin
      errors++;
      $display("FAIL fetch_stall0 got %b want 1", stall);
    end
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_addr, if_rvalid, stall} !== {1'b1, 1'b0, 32'h10, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL fetch_grant got req=%b we=%b addr=%h rv=%b st=%b want 1 0 10 0 1",
               mem_req, mem_we, mem_addr, if_rvalid, stall);
    end
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata, stall, mem_req, dm_rvalid} !== {1'b1, 32'h0050_0093, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL fetch_resp got rv=%b data=%h st=%b req=%b drv=%b want 1 00500093 0 0 0",
               if_rvalid, if_rdata, stall, mem_req, dm_rvalid);
    end
    if_req = 1'b0;
    @(negedge clk);
    checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 32'h0050_0093}) begin
      errors++;
      $display("FAIL fetch_hold got rv=%b data=%h want 0 00500093", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_store();
    int if_seen;
    if_seen = 0;
    lat = 1;
    rdata_val = 32'h1234_5678;
    dm_we = 1'b1;
    dm_addr = 32'h100;
    dm_wdata = 32'hDEAD_BEEF;
    dm_req = 1'b1;
    @(negedge clk);
    if (if_rvalid) if_seen++;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF}) begin
      errors++;
      $display("FAIL store_grant got req=%b we=%b addr=%h wd=%h want 1 1 100 deadbeef",
               mem_req, mem_we, mem_addr, mem_wdata);
    end
    @(negedge clk);
    if (if_rvalid) if_seen++;
    checks++;
    if ({dm_rvalid, dm_rdata} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL store_resp got rv=%b data=%h want 1 0", dm_rvalid, dm_rdata);
    end
    dm_req = 1'b0;
    dm_we = 1'b0;
    @(negedge clk);
    if (if_rvalid) if_seen++;
    checks++;
    if (if_seen !== 0) begin
      errors++;
      $display("FAIL store_no_if got %0d want 0", if_seen);
    end
  endtask

  task automatic test_varlat();
    int nreq, nrv, unstable;
    nreq = 0;
    nrv = 0;
    unstable = 0;
    lat = 5;
    rdata_val = 32'hCAFE_F00D;
    dm_we = 1'b0;
    dm_addr = 32'h300;
    dm_wdata = 32'hA5A5_A5A5;
    dm_req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (mem_req) begin
        nreq++;
        if (mem_addr !== 32'h300 || mem_wdata !== 32'hA5A5_A5A5) unstable++;
      end
      if (dm_rvalid) begin
        nrv++;
        checks++;
        if (dm_rdata !== 32'hCAFE_F00D) begin
          errors++;
          $display("FAIL varlat_data got %h want cafef00d", dm_rdata);
        end
        dm_req = 1'b0;
      end
    end
    checks++;
    if ({nreq, nrv, unstable} !== {32'd5, 32'd1, 32'd0}) begin
      errors++;
      $display("FAIL varlat_shape got req=%0d rv=%0d unstable=%0d want 5 1 0",
               nreq, nrv, unstable);
    end
  endtask

  task automatic test_contention();
    logic [31:0] exp_a [6];
    logic [31:0] got [6];
    int   n;
    logic prev;
    exp_a = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h40, 32'h80};
    got = '{default: 32'h0};
    n = 0;
    prev = 1'b0;
    lat = 1;
    rdata_val = 32'h5555_0000;
    if_addr = 32'h40;
    dm_addr = 32'h80;
    dm_we = 1'b0;
    dm_wdata = '0;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int c = 0; c < 60 && n < 6; c++) begin
      @(negedge clk);
      if (mem_req && !prev) begin
        got[n] = mem_addr;
        if (mem_addr == 32'h40) begin
          checks++;
          if (mem_we !== 1'b0) begin
            errors++;
            $display("FAIL cont_if_we got %b want 0", mem_we);
          end
        end
        n++;
      end
      prev = mem_req;
    end
    for (int c = 0; c < 10 && !dm_rvalid; c++) @(negedge clk);
    checks++;
    if (dm_rvalid !== 1'b1) begin
      errors++;
      $display("FAIL cont_last_rv got %b want 1", dm_rvalid);
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (got[i] !== exp_a[i]) begin
        errors++;
        $display("FAIL cont_grant%0d got %h want %h", i, got[i], exp_a[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int  cnt;
    logic done;
    cnt = 0;
    done = 1'b0;
    lat = 0;
    rdata_val = 32'h7777_7777;
    dm_we = 1'b0;
    dm_addr = 32'h200;
    dm_req = 1'b1;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (mem_req) cnt++;
      else if (cnt > 0) done = 1'b1;
    end
    checks++;
    if (cnt !== 64) begin
      errors++;
      $display("FAIL tmo_cycles got %0d want 64", cnt);
    end
    checks++;
    if ({done, dm_rvalid, dm_rdata, timeout_err} !== {1'b1, 1'b1, 32'h0, 1'b1}) begin
      errors++;
      $display("FAIL tmo_resp got done=%b rv=%b data=%h err=%b want 1 1 0 1",
               done, dm_rvalid, dm_rdata, timeout_err);
    end
    dm_req = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({timeout_err, dm_rvalid} !== 2'b10) begin
      errors++;
      $display("FAIL tmo_sticky got err=%b rv=%b want 1 0", timeout_err, dm_rvalid);
    end
  endtask

  task automatic test_reset_mid();
    int nrv;
    nrv = 0;
    lat = 0;
    rdata_val = 32'h1111_1111;
    if_addr = 32'h20;
    if_req = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rmid_busy got %b want 1", mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({mem_req, if_rvalid, timeout_err} !== 3'b000) begin
      errors++;
      $display("FAIL rmid_abort got req=%b rv=%b err=%b want 0 0 0",
               mem_req, if_rvalid, timeout_err);
    end
    rst = 1'b0;
    lat = 2;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (if_rvalid) begin
        nrv++;
        checks++;
        if (if_rdata !== 32'h1111_1111) begin
          errors++;
          $display("FAIL rmid_data got %h want 11111111", if_rdata);
        end
        if_req = 1'b0;
      end
    end
    checks++;
    if (nrv !== 1) begin
      errors++;
      $display("FAIL rmid_rv_count got %0d want 1", nrv);
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_varlat();
    test_contention();
    test_timeout();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
